// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-update control path: sequencer states,
// next-PC mux select codes, exception cause codes and the request-kind map.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EPC_SAVE = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_MDR_LOAD = 3'd3,
    ST_PC_LOAD  = 3'd4
  } state_t;

  // Next-PC mux select codes.
  localparam logic [2:0] PCS_MDR    = 3'b000;
  localparam logic [2:0] PCS_ALU    = 3'b001;
  localparam logic [2:0] PCS_ALUOUT = 3'b010;
  localparam logic [2:0] PCS_CONCAT = 3'b011;
  localparam logic [2:0] PCS_EPC    = 3'b100;

  // Latched exception cause.
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE   = 2'd1;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;
  localparam logic [1:0] CAUSE_DIV0     = 2'd3;

  // Request kinds from the main control unit.
  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_ALUOUT = 2'd1;
  localparam logic [1:0] KIND_CONCAT = 2'd2;
  localparam logic [1:0] KIND_EPC    = 2'd3;

  // Map a request kind onto its next-PC mux select. The MDR path is never
  // reachable from a normal request; only the exception sequence uses it.
  function automatic logic [2:0] kind_to_source(input logic [1:0] kind);
    logic [2:0] src;
    case (kind)
      KIND_ALU:    src = PCS_ALU;
      KIND_ALUOUT: src = PCS_ALUOUT;
      KIND_CONCAT: src = PCS_CONCAT;
      default:     src = PCS_EPC;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/exc_pc_sequencer.sv
// Next-PC mux controller: passes normal PC-update requests straight through
// and, on an exception, runs the EPC save / vector fetch / PC load sequence.
module exc_pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [31:0] VEC_OPCODE = 32'h0000_00FD,
  parameter logic [31:0] VEC_OVF    = 32'h0000_00FE,
  parameter logic [31:0] VEC_DIV0   = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_req,
  input  logic [1:0]  pc_kind,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] exc_addr,
  output logic        exc_addr_sel,
  output logic        mem_read,
  output logic        mdr_write,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        exc_done
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;
  logic [31:0]      r_exc_addr;

  logic             w_exc_any;
  logic [1:0]       w_cause_sel;
  logic [31:0]      w_vec_sel;

  assign w_exc_any = exc_opcode | exc_overflow | exc_div0;

  // Resolve simultaneous exceptions: opcode > overflow > div0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    w_cause_sel = CAUSE_NONE;
    w_vec_sel   = '0;
    if (exc_opcode) begin
      w_cause_sel = CAUSE_OPCODE;
      w_vec_sel   = VEC_OPCODE;
    end else if (exc_overflow) begin
      w_cause_sel = CAUSE_OVERFLOW;
      w_vec_sel   = VEC_OVF;
    end else if (exc_div0) begin
      w_cause_sel = CAUSE_DIV0;
      w_vec_sel   = VEC_DIV0;
    end
  end

  // Sequencer state, memory wait counter and latched cause/vector.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop in this
    // block samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cause    <= CAUSE_NONE;
      r_exc_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc_any) begin
            r_state    <= ST_EPC_SAVE;
            r_cause    <= w_cause_sel;
            r_exc_addr <= w_vec_sel;
          end
        end
        ST_EPC_SAVE: begin
          r_state <= ST_MEM_WAIT;
          r_cnt   <= CNT_LOAD;
        end
        ST_MEM_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_MDR_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_MDR_LOAD: r_state <= ST_PC_LOAD;
        ST_PC_LOAD:  r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: Moore strobes per sequence state, pass-through in IDLE.
  always_comb begin
    pc_source    = PCS_ALU;
    pc_write     = 1'b0;
    epc_write    = 1'b0;
    exc_addr_sel = 1'b0;
    mem_read     = 1'b0;
    mdr_write    = 1'b0;
    busy         = 1'b1;
    exc_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pc_req) begin
          pc_source = kind_to_source(pc_kind);
        end
        // A pending exception wins over a same-cycle normal update.
        pc_write = pc_req & ~w_exc_any;
      end
      ST_EPC_SAVE: epc_write = 1'b1;
      ST_MEM_WAIT: begin
        exc_addr_sel = 1'b1;
        mem_read     = 1'b1;
      end
      ST_MDR_LOAD: begin
        exc_addr_sel = 1'b1;
        mem_read     = 1'b1;
        mdr_write    = 1'b1;
      end
      ST_PC_LOAD: begin
        pc_source = PCS_MDR;
        pc_write  = 1'b1;
        exc_done  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign cause    = r_cause;
  assign exc_addr = r_exc_addr;

endmodule
